// File: rtl/id_hazard_stall_ctrl_if.sv
// Hazard-controller bundle between the ID/EX/MEM pipeline and the stall unit.
// master: pipeline side (drives hazard inputs, reads stall/flush controls).
// slave : stall controller (reads hazard inputs, drives controls/counters).
interface id_hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_is_branch;
    logic             id_is_jr;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       ex_rw;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [4:0]       mem_rw;
    logic             mem_regwrite;
    logic             mem_memread;
    logic             id_br_taken;
    logic             id_jump;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_is_branch, id_is_jr, id_use_rs, id_use_rt,
        output id_rs, id_rt,
        output ex_rw, ex_regwrite, ex_memread,
        output mem_rw, mem_regwrite, mem_memread,
        output id_br_taken, id_jump,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_is_branch, id_is_jr, id_use_rs, id_use_rt,
        input  id_rs, id_rt,
        input  ex_rw, ex_regwrite, ex_memread,
        input  mem_rw, mem_regwrite, mem_memread,
        input  id_br_taken, id_jump,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: load-use and branch-operand stalls,
// IF/ID flush on taken branch/jump, saturating stall/flush perf counters.
// Ports: clk, reset (async, active-high), hz (slave side of the bundle):
//   in : id_* decode info, ex_*/mem_* destination info, id_br_taken, id_jump
//   out: pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_cnt, flush_cnt
module id_hazard_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter bit LOAD_USE_EN = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    id_hazard_stall_ctrl_if.slave hz
);
    typedef enum logic {
        RUN    = 1'b0,
        STALL2 = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_brsrc;
    logic w_hit_ex;
    logic w_hit_mem;
    logic w_need2;
    logic w_need1;
    logic w_stall;
    logic w_flush;

    assign w_brsrc = hz.id_is_branch | hz.id_is_jr;

    assign w_hit_ex = hz.ex_regwrite && (hz.ex_rw != 5'd0) &&
                      ((hz.id_use_rs && (hz.id_rs == hz.ex_rw)) ||
                       (hz.id_use_rt && (hz.id_rt == hz.ex_rw)));

    assign w_hit_mem = hz.mem_regwrite && (hz.mem_rw != 5'd0) &&
                       ((hz.id_use_rs && (hz.id_rs == hz.mem_rw)) ||
                        (hz.id_use_rt && (hz.id_rt == hz.mem_rw)));

    // Load in EX feeding an ID compare needs the load to reach WB-forward
    // range, two cycles away; everything else resolves in one.
    assign w_need2 = w_brsrc && w_hit_ex && hz.ex_memread;

    assign w_need1 = (w_brsrc && w_hit_ex && !hz.ex_memread) ||
                     (w_brsrc && w_hit_mem && hz.mem_memread) ||
                     (LOAD_USE_EN && !w_brsrc && w_hit_ex && hz.ex_memread);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        unique case (r_state)
            RUN: begin
                w_stall = w_need2 | w_need1;
                if (w_need2) begin
                    w_state_nxt = STALL2;
                end
            end
            STALL2: begin
                // Second cycle is committed; hazard inputs not re-checked.
                w_stall     = 1'b1;
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
        // Reset forces the controls inactive regardless of live inputs.
        if (reset) begin
            w_stall = 1'b0;
        end
    end

    // Stall wins over flush: branch outcome is not valid while stalling.
    assign w_flush = !reset && !w_stall &&
                     (hz.id_jump | (hz.id_is_branch & hz.id_br_taken));

    assign hz.pc_write     = ~w_stall;
    assign hz.if_id_write  = ~w_stall;
    assign hz.id_ex_bubble = w_stall;
    assign hz.if_id_flush  = w_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_id_hazard_stall_ctrl.sv
// Directed bench for id_hazard_stall_ctrl: default instance (CNT_W=16,
// load-use on) and a narrow one (CNT_W=4, load-use off) on shared inputs.
module tb_id_hazard_stall_ctrl;
    logic clk;
    logic reset;

    logic       id_is_branch;
    logic       id_is_jr;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_rw;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] mem_rw;
    logic       mem_regwrite;
    logic       mem_memread;
    logic       id_br_taken;
    logic       id_jump;

    int n_tot;
    int n_bad;

    id_hazard_stall_ctrl_if #(.CNT_W(16)) hz1 ();
    id_hazard_stall_ctrl_if #(.CNT_W(4))  hz2 ();

    assign hz1.id_is_branch = id_is_branch;
    assign hz1.id_is_jr     = id_is_jr;
    assign hz1.id_use_rs    = id_use_rs;
    assign hz1.id_use_rt    = id_use_rt;
    assign hz1.id_rs        = id_rs;
    assign hz1.id_rt        = id_rt;
    assign hz1.ex_rw        = ex_rw;
    assign hz1.ex_regwrite  = ex_regwrite;
    assign hz1.ex_memread   = ex_memread;
    assign hz1.mem_rw       = mem_rw;
    assign hz1.mem_regwrite = mem_regwrite;
    assign hz1.mem_memread  = mem_memread;
    assign hz1.id_br_taken  = id_br_taken;
    assign hz1.id_jump      = id_jump;

    assign hz2.id_is_branch = id_is_branch;
    assign hz2.id_is_jr     = id_is_jr;
    assign hz2.id_use_rs    = id_use_rs;
    assign hz2.id_use_rt    = id_use_rt;
    assign hz2.id_rs        = id_rs;
    assign hz2.id_rt        = id_rt;
    assign hz2.ex_rw        = ex_rw;
    assign hz2.ex_regwrite  = ex_regwrite;
    assign hz2.ex_memread   = ex_memread;
    assign hz2.mem_rw       = mem_rw;
    assign hz2.mem_regwrite = mem_regwrite;
    assign hz2.mem_memread  = mem_memread;
    assign hz2.id_br_taken  = id_br_taken;
    assign hz2.id_jump      = id_jump;

    id_hazard_stall_ctrl #(.CNT_W(16), .LOAD_USE_EN(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz1)
    );

    id_hazard_stall_ctrl #(.CNT_W(4), .LOAD_USE_EN(1'b0)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .hz    (hz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_is_branch = 0; id_is_jr = 0; id_use_rs = 0; id_use_rt = 0;
        id_rs = 0; id_rt = 0;
        ex_rw = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rw = 0; mem_regwrite = 0; mem_memread = 0;
        id_br_taken = 0; id_jump = 0;
    endtask

    // Advance one clock; land 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check the four controls of one instance: {pc_wr, ifid_wr, bubble, flush}.
    task automatic ctl1(input string tag, input logic [3:0] exp);
        chk(tag, {hz1.pc_write, hz1.if_id_write,
                  hz1.id_ex_bubble, hz1.if_id_flush}, {28'd0, exp});
    endtask

    task automatic ctl2(input string tag, input logic [3:0] exp);
        chk(tag, {hz2.pc_write, hz2.if_id_write,
                  hz2.id_ex_bubble, hz2.if_id_flush}, {28'd0, exp});
    endtask

    // Branch (or non-branch) reading rs/rt.
    task automatic id_set(input logic br, input logic [4:0] rs,
                          input logic [4:0] rt, input logic tk);
        id_is_branch = br; id_use_rs = 1; id_use_rt = 1;
        id_rs = rs; id_rt = rt; id_br_taken = tk;
    endtask

    localparam logic [3:0] RUNC  = 4'b1100;
    localparam logic [3:0] STALC = 4'b0010;
    localparam logic [3:0] FLSHC = 4'b1101;

    initial begin
        n_tot = 0;
        n_bad = 0;
        clr();
        reset = 1'b1;
        // Live need=2 hazard plus jump while in reset: must be ignored.
        id_set(1, 5'd8, 5'd9, 1);
        id_jump = 1;
        ex_rw = 8; ex_regwrite = 1; ex_memread = 1;
        cyc();
        cyc();
        ctl1("rst_ctl", RUNC);
        ctl2("rst_ctl2", RUNC);
        chk("rst_sc", hz1.stall_cnt, 0);
        chk("rst_fc", hz1.flush_cnt, 0);
        clr();
        reset = 1'b0;
        #1;
        ctl1("idle", RUNC);

        // 1: lw $8 in EX, beq $8,$9 in ID -> two committed stall cycles.
        cyc();
        ex_rw = 8; ex_regwrite = 1; ex_memread = 1;
        id_set(1, 5'd8, 5'd9, 1);
        #1;
        ctl1("t1_s1", STALC);
        ctl2("t1_s1b", STALC);
        cyc();
        ex_regwrite = 0; ex_memread = 0; ex_rw = 0;
        #1;
        ctl1("t1_s2", STALC);
        chk("t1_sc1", hz1.stall_cnt, 1);
        cyc();
        #1;
        ctl1("t1_flush", FLSHC);
        chk("t1_sc2", hz1.stall_cnt, 2);
        chk("t1_sc2b", hz2.stall_cnt, 2);
        cyc();
        chk("t1_fc", hz1.flush_cnt, 1);
        clr();

        // 2: add $8 in EX, bne $8,$0 in ID -> one stall, then flush.
        ex_rw = 8; ex_regwrite = 1;
        id_set(1, 5'd8, 5'd0, 1);
        #1;
        ctl1("t2_s", STALC);
        cyc();
        ex_rw = 0;
        mem_rw = 8; mem_regwrite = 1;
        #1;
        ctl1("t2_flush", FLSHC);
        chk("t2_sc", hz1.stall_cnt, 3);
        cyc();
        chk("t2_fc", hz1.flush_cnt, 2);
        clr();

        // 3: lw $8 in EX, add $3,$8,$1 in ID: load-use on vs off.
        ex_rw = 8; ex_regwrite = 1; ex_memread = 1;
        id_set(0, 5'd8, 5'd1, 0);
        #1;
        ctl1("t3_lu_on", STALC);
        ctl2("t3_lu_off", RUNC);
        cyc();
        chk("t3_sc", hz1.stall_cnt, 4);
        chk("t3_sc2", hz2.stall_cnt, 3);
        ex_rw = 0; id_rs = 0; id_rt = 0;
        #1;
        ctl1("t3_r0", RUNC);
        cyc();
        clr();

        // 4: ALU result in MEM is forwarded; load in MEM is not.
        mem_rw = 8; mem_regwrite = 1;
        id_set(1, 5'd8, 5'd2, 0);
        #1;
        ctl1("t4_memalu", RUNC);
        cyc();
        clr();
        id_jump = 1;
        #1;
        ctl1("t4_jump", FLSHC);
        cyc();
        clr();
        chk("t4_fc", hz1.flush_cnt, 3);
        mem_rw = 8; mem_regwrite = 1; mem_memread = 1;
        id_is_jr = 1; id_use_rs = 1; id_rs = 8; id_jump = 1;
        #1;
        ctl1("t4_memld", STALC);
        cyc();
        clr();
        #1;
        ctl1("t4_memld_end", RUNC);
        chk("t4_sc", hz1.stall_cnt, 5);

        // 5: reset asserted during STALL2 aborts it immediately.
        ex_rw = 8; ex_regwrite = 1; ex_memread = 1;
        id_set(1, 5'd8, 5'd9, 1);
        cyc();
        #1;
        ctl1("t5_pre", STALC);
        id_jump = 1;
        reset = 1'b1;
        #1;
        ctl1("t5_rst", RUNC);
        chk("t5_sc", hz1.stall_cnt, 0);
        chk("t5_fc", hz1.flush_cnt, 0);
        cyc();
        clr();
        reset = 1'b0;
        #1;
        ctl1("t5_post", RUNC);
        cyc();
        chk("t5_sc_post", hz1.stall_cnt, 0);

        // 6: 20 stall cycles; narrow counter saturates at 15.
        ex_rw = 8; ex_regwrite = 1;
        id_set(1, 5'd8, 5'd0, 1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (i == 14) begin
                chk("t6_sc2_15", hz2.stall_cnt, 15);
            end
        end
        ctl2("t6_stall", STALC);
        chk("t6_sc2", hz2.stall_cnt, 15);
        chk("t6_sc", hz1.stall_cnt, 20);
        chk("t6_fc2", hz2.flush_cnt, 0);
        chk("t6_fc", hz1.flush_cnt, 0);
        clr();
        cyc();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
